// File: rtl/spi_accel_pkg.sv
// spi_accel_pkg: shared definitions for the SPI accelerometer target.
//   CMD_WRITE / CMD_READ : command byte codes
//   ADDR_DEVID           : address that always reads the device ID
//   state_t              : frame decoder states
package spi_accel_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h0A;
    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam int         ADDR_DEVID = 0;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer for an asynchronous input plus
// rise/fall detection on the synchronized value.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input
//   q        : synchronized value (reset to RST_VAL)
//   rise     : q went 0->1 this cycle (previous vs current synced value)
//   fall     : q went 1->0 this cycle
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the one before it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_accel_target.sv
// spi_accel_target: SPI mode-3 target with a 64-byte register file.
//   clk, rst          : system clock, async active-high reset
//   CS, spi_clk, MOSI : SPI bus from the master (asynchronous to clk)
//   MISO, MISO_OE     : SPI read data and its output enable
//   loc_we/addr/wdata : local register write port
//   spi_wr_strobe/addr/data : one-cycle notification of an SPI-committed byte
//   frame_err         : sticky error (unknown command or frame cut mid-byte)
module spi_accel_target
    import spi_accel_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = 8'hAD,
    parameter int         ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              spi_clk,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic              loc_we,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic              spi_wr_strobe,
    output logic [ADDR_W-1:0] spi_wr_addr,
    output logic [7:0]        spi_wr_data,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] DEVID_A = ADDR_W'(ADDR_DEVID);

    logic cs_s, cs_rise, cs_fall_unused;
    logic sck_rise, sck_fall, sck_s_unused;
    logic mosi_s;
    logic [1:0] mosi_edges_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(CS),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall_unused)
    );
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sck (
        .clk(clk), .rst(rst), .din(spi_clk),
        .q(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .q(mosi_s), .rise(mosi_edges_unused[0]), .fall(mosi_edges_unused[1])
    );

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sh;
    logic [7:0]        tx_sh;
    logic [ADDR_W-1:0] addr;
    logic              wr_mode;
    // Set once CS has been seen high since reset, so a frame interrupted by
    // reset is never picked up half-way.
    logic              armed;
    logic [7:0]        regs [2**ADDR_W];

    logic [7:0] rx_byte;
    assign rx_byte = {rx_sh, mosi_s};

    // The output enable is the synced chip select itself, no extra stage.
    assign MISO_OE = ~cs_s;

    function automatic logic [7:0] rd_reg(input logic [ADDR_W-1:0] a);
        return (a == DEVID_A) ? DEVICE_ID : regs[a];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            addr          <= '0;
            wr_mode       <= 1'b0;
            armed         <= 1'b0;
            MISO          <= 1'b0;
            spi_wr_strobe <= 1'b0;
            spi_wr_addr   <= '0;
            spi_wr_data   <= '0;
            frame_err     <= 1'b0;
            // NOTE: the register file is reset explicitly because its
            // contents after reset are architecturally visible (all zero).
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else begin
            spi_wr_strobe <= 1'b0;
            if (cs_s) armed <= 1'b1;

            // Local write first; an SPI commit to the same address later in
            // this block overrides it.
            if (loc_we && loc_addr != DEVID_A) regs[loc_addr] <= loc_wdata;

            if (cs_rise) begin
                if (bit_cnt != 3'd0 && state != IGNORE && state != IDLE)
                    frame_err <= 1'b1;
                state   <= IDLE;
                bit_cnt <= '0;
                tx_sh   <= '0;
                MISO    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!cs_s && armed) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            tx_sh   <= '0;
                        end
                    end
                    IGNORE: ;
                    default: begin
                        if (sck_fall) begin
                            MISO  <= tx_sh[7];
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                        if (sck_rise) begin
                            rx_sh   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (state)
                                    CMD: begin
                                        if (rx_byte == CMD_WRITE) begin
                                            wr_mode <= 1'b1;
                                            state   <= ADDR;
                                        end else if (rx_byte == CMD_READ) begin
                                            wr_mode <= 1'b0;
                                            state   <= ADDR;
                                        end else begin
                                            frame_err <= 1'b1;
                                            state     <= IGNORE;
                                        end
                                    end
                                    ADDR: begin
                                        if (wr_mode) begin
                                            addr  <= rx_byte[ADDR_W-1:0];
                                            state <= WDATA;
                                        end else begin
                                            // First read byte is loaded here, so the
                                            // pointer already moves past it.
                                            tx_sh <= rd_reg(rx_byte[ADDR_W-1:0]);
                                            addr  <= rx_byte[ADDR_W-1:0] + 1'b1;
                                            state <= RDATA;
                                        end
                                    end
                                    WDATA: begin
                                        if (addr != DEVID_A) regs[addr] <= rx_byte;
                                        spi_wr_strobe <= 1'b1;
                                        spi_wr_addr   <= addr;
                                        spi_wr_data   <= rx_byte;
                                        addr          <= addr + 1'b1;
                                    end
                                    RDATA: begin
                                        tx_sh <= rd_reg(addr);
                                        addr  <= addr + 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_accel_target.sv
// tb_spi_accel_target: drives SPI mode-3 frames and local writes into
// spi_accel_target and checks MISO bytes, write strobes and frame_err
// against fixed vectors and a register-array reference model.
module tb_spi_accel_target;

    localparam int H = 10;  // spi_clk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       CS, spi_clk, MOSI;
    logic       MISO, MISO_OE;
    logic       loc_we;
    logic [5:0] loc_addr;
    logic [7:0] loc_wdata;
    logic       spi_wr_strobe;
    logic [5:0] spi_wr_addr;
    logic [7:0] spi_wr_data;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_accel_target #(.DEVICE_ID(8'hAD), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .CS(CS), .spi_clk(spi_clk), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .spi_wr_strobe(spi_wr_strobe), .spi_wr_addr(spi_wr_addr),
        .spi_wr_data(spi_wr_data), .frame_err(frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Strobes seen on the write-notification port, as {addr, data}.
    logic [13:0] got_q[$];
    always @(negedge clk) if (spi_wr_strobe) got_q.push_back({spi_wr_addr, spi_wr_data});

    // Reference model: plain register array with the address-0 rule.
    logic [7:0] mregs[64];
    function automatic logic [7:0] mread(input logic [5:0] a);
        return (a == 6'd0) ? 8'hAD : mregs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            MOSI    = b[7-i];
            tick(H);
            spi_clk = 1'b1;
            rx      = {rx[6:0], MISO};
            tick(H);
        end
    endtask

    task automatic run_frame(input logic [7:0] fb[8], input int n, output logic [7:0] mo[8]);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) mo[k] = '0;
        got_q.delete();
        CS = 1'b0;
        tick(6);
        for (int k = 0; k < n; k++) begin
            xfer_bits(fb[k], 8, r);
            mo[k] = r;
        end
        tick(6);
        CS = 1'b1;
        tick(12);
    endtask

    task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        tick(1);
        loc_we    = 1'b0;
        if (a != 6'd0) mregs[a] = d;
    endtask

    // Frame checked entirely against the reference model.
    task automatic model_frame(input logic [7:0] fb[8], input int n, input logic exp_err);
        logic [7:0]  exp_mo[8];
        logic [7:0]  mo[8];
        logic [13:0] exp_s[$];
        logic [5:0]  a, aa;
        a = fb[1][5:0];
        for (int k = 0; k < 8; k++) exp_mo[k] = '0;
        for (int k = 2; k < n; k++) begin
            aa = a + 6'(k - 2);
            if (fb[0] == 8'h0B) exp_mo[k] = mread(aa);
        end
        for (int k = 2; k < n; k++) begin
            aa = a + 6'(k - 2);
            if (fb[0] == 8'h0A) begin
                exp_s.push_back({aa, fb[k]});
                if (aa != 6'd0) mregs[aa] = fb[k];
            end
        end
        run_frame(fb, n, mo);
        for (int k = 0; k < n; k++) check($sformatf("miso[%0d] cmd %0h addr %0h", k, fb[0], fb[1]), mo[k], exp_mo[k]);
        check("strobe count", got_q.size(), exp_s.size());
        for (int i = 0; i < exp_s.size() && i < got_q.size(); i++)
            check($sformatf("strobe[%0d]", i), got_q[i], exp_s[i]);
        check("frame_err", frame_err, exp_err);
    endtask

    typedef struct {
        logic [7:0] b[8];
        int         n;
        logic [7:0] mo[8];
        int         ns;
        logic       err;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [7:0] fb[8];
        logic [7:0] mo[8];
        logic [7:0] r;

        rst = 1'b1; CS = 1'b1; spi_clk = 1'b1; MOSI = 1'b0;
        loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
        for (int i = 0; i < 64; i++) mregs[i] = '0;
        tick(3);
        check("reset MISO", MISO, 0);
        check("reset MISO_OE", MISO_OE, 0);
        check("reset strobe", spi_wr_strobe, 0);
        check("reset wr_addr", spi_wr_addr, 0);
        check("reset wr_data", spi_wr_data, 0);
        check("reset frame_err", frame_err, 0);
        rst = 1'b0;
        tick(5);

        // Local loads, including an ignored write to the ID address.
        loc_write(6'h08, 8'h5A);
        loc_write(6'h09, 8'hA5);
        loc_write(6'h00, 8'h77);

        tbl[0].b = '{8'h0B, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[0].n = 3; tbl[0].ns = 0; tbl[0].err = 1'b0;
        tbl[0].mo = '{8'h00, 8'h00, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1].b = '{8'h0A, 8'h3E, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
        tbl[1].n = 5; tbl[1].ns = 3; tbl[1].err = 1'b0;
        tbl[1].mo = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].b = '{8'h0B, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2].n = 5; tbl[2].ns = 0; tbl[2].err = 1'b0;
        tbl[2].mo = '{8'h00, 8'h00, 8'h11, 8'h22, 8'hAD, 8'h00, 8'h00, 8'h00};
        tbl[3].b = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3].n = 4; tbl[3].ns = 0; tbl[3].err = 1'b0;
        tbl[3].mo = '{8'h00, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};

        for (int t = 0; t < 4; t++) begin
            run_frame(tbl[t].b, tbl[t].n, mo);
            for (int k = 0; k < tbl[t].n; k++)
                check($sformatf("vec%0d miso[%0d]", t, k), mo[k], tbl[t].mo[k]);
            check($sformatf("vec%0d strobes", t), got_q.size(), tbl[t].ns);
            check($sformatf("vec%0d frame_err", t), frame_err, tbl[t].err);
            if (t == 1 && got_q.size() == 3) begin
                check("vec1 strobe0", got_q[0], {6'h3E, 8'h11});
                check("vec1 strobe1", got_q[1], {6'h3F, 8'h22});
                check("vec1 strobe2", got_q[2], {6'h00, 8'h33});
            end
            // Keep the model in step with table writes.
            if (tbl[t].b[0] == 8'h0A)
                for (int k = 2; k < tbl[t].n; k++) begin
                    logic [5:0] aa;
                    aa = tbl[t].b[1][5:0] + 6'(k - 2);
                    if (aa != 6'd0) mregs[aa] = tbl[t].b[k];
                end
        end

        // Randomized frames and local writes against the model.
        for (int r_i = 0; r_i < 24; r_i++) begin
            if ($urandom_range(0, 2) == 0)
                loc_write(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
            for (int k = 0; k < 8; k++) fb[k] = 8'($urandom_range(0, 255));
            fb[0] = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0B;
            model_frame(fb, $urandom_range(3, 6), 1'b0);
        end

        // Unknown command: ignored frame, sticky error.
        fb = '{8'h3C, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(fb, 4, mo);
        for (int k = 0; k < 4; k++) check($sformatf("badcmd miso[%0d]", k), mo[k], 8'h00);
        check("badcmd strobes", got_q.size(), 0);
        check("badcmd frame_err", frame_err, 1);

        // Write byte cut after 5 bits: discarded.
        got_q.delete();
        CS = 1'b0;
        tick(6);
        xfer_bits(8'h0A, 8, r);
        xfer_bits(8'h05, 8, r);
        xfer_bits(8'hE7, 5, r);
        tick(6);
        CS = 1'b1;
        tick(12);
        check("abort strobes", got_q.size(), 0);
        check("abort frame_err", frame_err, 1);
        fb = '{8'h0B, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(fb, 3, 1'b1);

        // Reset in the middle of a read data byte.
        CS = 1'b0;
        tick(6);
        xfer_bits(8'h0B, 8, r);
        xfer_bits(8'h08, 8, r);
        xfer_bits(8'h00, 3, r);
        rst = 1'b1;
        @(negedge clk);
        check("midrst MISO", MISO, 0);
        check("midrst MISO_OE", MISO_OE, 0);
        check("midrst strobe", spi_wr_strobe, 0);
        check("midrst wr_addr", spi_wr_addr, 0);
        check("midrst wr_data", spi_wr_data, 0);
        check("midrst frame_err", frame_err, 0);
        tick(3);
        CS = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(10);
        for (int i = 0; i < 64; i++) mregs[i] = '0;
        fb = '{8'h0A, 8'h10, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(fb, 3, 1'b0);
        fb = '{8'h0B, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(fb, 4, 1'b0);
        fb = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(fb, 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
